// File: rtl/xcvr_lane_reset_seq.sv
// xcvr_lane_reset_seq
// Reset/lock sequencer placed behind the transceiver TX PLL. PLL and CDR lock
// are synchronised and each must hold steady for LOCK_STABLE_CYCLES before the
// lane TX and then RX paths are declared ready. A lock-wait timeout pulse and a
// saturating count of qualified PLL-lock losses are reported upstream.
// STATE exposes the FSM encoding for debug and checker binding.
`timescale 1ns/1ps
module xcvr_lane_reset_seq #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  input  logic       CDR_LOCK,
  output logic       TX_RESET_N,
  output logic       RX_RESET_N,
  output logic       TX_READY,
  output logic       RX_READY,
  output logic       TIMEOUT,
  output logic [7:0] LOCK_LOST_CNT,
  output logic [2:0] STATE
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                           LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RST      = 3'd0,
    ST_WAIT_PLL = 3'd1,
    ST_PLL_STAB = 3'd2,
    ST_WAIT_CDR = 3'd3,
    ST_CDR_STAB = 3'd4,
    ST_READY    = 3'd5
  } state_t;

  logic          pll_meta_q, pll_s_q;
  logic          cdr_meta_q, cdr_s_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    lost_q, lost_d;
  logic          tx_rst_n_q, tx_rst_n_d;
  logic          rx_rst_n_q, rx_rst_n_d;
  logic          tx_ready_q, tx_ready_d;
  logic          rx_ready_q, rx_ready_d;
  logic          pll_loss;

  // Two-flop synchronisers; only the second stage feeds the FSM.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pll_meta_q <= 1'b0;
      pll_s_q    <= 1'b0;
      cdr_meta_q <= 1'b0;
      cdr_s_q    <= 1'b0;
    end else begin
      pll_meta_q <= PLL_LOCK;
      pll_s_q    <= pll_meta_q;
      cdr_meta_q <= CDR_LOCK;
      cdr_s_q    <= cdr_meta_q;
    end
  end

  // Next-state, shared counter, loss counting and output decode from next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    lost_d    = lost_q;
    pll_loss  = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_WAIT_PLL;
      ST_WAIT_PLL: begin
        if (pll_s_q) begin
          state_d = ST_PLL_STAB;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PLL_STAB: begin
        // A drop here is an unqualified lock, so it is not counted as a loss.
        if (!pll_s_q)                  state_d = ST_WAIT_PLL;
        else if (cnt_q == STABLE_LAST) state_d = ST_WAIT_CDR;
        else                           cnt_d   = cnt_q + CW'(1);
      end
      ST_WAIT_CDR: begin
        if (!pll_s_q) begin
          state_d  = ST_WAIT_PLL;
          pll_loss = 1'b1;
        end else if (cdr_s_q) begin
          state_d = ST_CDR_STAB;
        end
      end
      ST_CDR_STAB: begin
        if (!pll_s_q) begin
          state_d  = ST_WAIT_PLL;
          pll_loss = 1'b1;
        end else if (!cdr_s_q) begin
          state_d = ST_WAIT_CDR;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_READY: begin
        // PLL loss takes priority over a simultaneous CDR loss.
        if (!pll_s_q) begin
          state_d  = ST_WAIT_PLL;
          pll_loss = 1'b1;
        end else if (!cdr_s_q) begin
          state_d = ST_WAIT_CDR;
        end
      end
      default: state_d = ST_RST;
    endcase

    if (state_d != state_q) cnt_d = '0;
    if (pll_loss && (lost_q != 8'hFF)) lost_d = lost_q + 8'd1;

    // RX reset is released with TX so the CDR can acquire lock.
    tx_rst_n_d = (state_d == ST_WAIT_CDR) || (state_d == ST_CDR_STAB) ||
                 (state_d == ST_READY);
    rx_rst_n_d = tx_rst_n_d;
    tx_ready_d = tx_rst_n_d;
    rx_ready_d = (state_d == ST_READY);
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_RST;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      lost_q     <= 8'd0;
      tx_rst_n_q <= 1'b0;
      rx_rst_n_q <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      lost_q     <= lost_d;
      tx_rst_n_q <= tx_rst_n_d;
      rx_rst_n_q <= rx_rst_n_d;
      tx_ready_q <= tx_ready_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign TX_RESET_N    = tx_rst_n_q;
  assign RX_RESET_N    = rx_rst_n_q;
  assign TX_READY      = tx_ready_q;
  assign RX_READY      = rx_ready_q;
  assign TIMEOUT       = timeout_q;
  assign LOCK_LOST_CNT = lost_q;
  assign STATE         = state_q;

endmodule

// File: tb/tb_xcvr_lane_reset_seq.sv
// Directed bench for xcvr_lane_reset_seq with LOCK_STABLE_CYCLES=8 and
// LOCK_TIMEOUT_CYCLES=32. Inputs change 1 time unit after a rising edge, so
// a change made after edge k is captured at edge k+1 (called E0 below).
// Outputs are sampled at the same offset, away from the active edge.
`timescale 1ns/1ps
module tb_xcvr_lane_reset_seq;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       cdr_lock;
  logic       tx_reset_n;
  logic       rx_reset_n;
  logic       tx_ready;
  logic       rx_ready;
  logic       timeout;
  logic [7:0] lock_lost_cnt;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  xcvr_lane_reset_seq #(
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32)
  ) dut (
    .CLK          (clk),
    .RESET        (rst),
    .PLL_LOCK     (pll_lock),
    .CDR_LOCK     (cdr_lock),
    .TX_RESET_N   (tx_reset_n),
    .RX_RESET_N   (rx_reset_n),
    .TX_READY     (tx_ready),
    .RX_READY     (rx_ready),
    .TIMEOUT      (timeout),
    .LOCK_LOST_CNT(lock_lost_cnt),
    .STATE        (state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic txn,
                            input logic rxn, input logic txr, input logic rxr);
    check({tag, ".state"},      32'(state),      32'(st));
    check({tag, ".tx_reset_n"}, 32'(tx_reset_n), 32'(txn));
    check({tag, ".rx_reset_n"}, 32'(rx_reset_n), 32'(rxn));
    check({tag, ".tx_ready"},   32'(tx_ready),   32'(txr));
    check({tag, ".rx_ready"},   32'(rx_ready),   32'(rxr));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (state === s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  int pulses;
  int pulse_at[3];
  bit wide;
  bit rst_hi;
  bit prev_to;
  bit ok;
  int to_cnt;

  initial begin
    rst = 1'b1;
    pll_lock = 1'b0;
    cdr_lock = 1'b0;
    step(3);

    // Reset values.
    check_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.timeout", 32'(timeout), 32'd0);
    check("reset.lost", 32'(lock_lost_cnt), 32'd0);

    // Timeout: PLL never locks for 100 cycles after release.
    rst = 1'b0;
    pulses = 0; wide = 1'b0; rst_hi = 1'b0; prev_to = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (timeout === 1'b1) begin
        if (pulses < 3) pulse_at[pulses] = i;
        pulses++;
        if (prev_to) wide = 1'b1;
      end
      prev_to = (timeout === 1'b1);
      if (tx_reset_n | rx_reset_n | tx_ready | rx_ready) rst_hi = 1'b1;
    end
    check("timeout.count", 32'(pulses), 32'd3);
    check("timeout.first", 32'(pulse_at[0]), 32'd33);
    check("timeout.second", 32'(pulse_at[1]), 32'd65);
    check("timeout.third", 32'(pulse_at[2]), 32'd97);
    check("timeout.wide", 32'(wide), 32'd0);
    check("timeout.resets_low", 32'(rst_hi), 32'd0);
    check("timeout.state", 32'(state), 32'd1);

    // Glitch during PLL stabilisation.
    apply_reset();
    step(1);
    pll_lock = 1'b1;
    step(3);
    check("glitch.pll_stab", 32'(state), 32'd2);
    step(3);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(1);
    check("glitch.still_stab", 32'(state), 32'd2);
    step(1);
    check("glitch.back_wait", 32'(state), 32'd1);
    check("glitch.lost", 32'(lock_lost_cnt), 32'd0);
    step(1);
    check("glitch.restab", 32'(state), 32'd2);
    step(7);
    check("glitch.not_early", 32'(state), 32'd2);
    step(1);
    check("glitch.wait_cdr", 32'(state), 32'd3);
    check("glitch.lost_after", 32'(lock_lost_cnt), 32'd0);

    // Clean bring-up: PLL captured at E0, CDR captured at E5.
    pll_lock = 1'b0;
    apply_reset();
    check("bringup.s0", 32'(state), 32'd0);
    step(1);
    check("bringup.s1", 32'(state), 32'd1);
    pll_lock = 1'b1;
    step(2);
    check("bringup.e1", 32'(state), 32'd1);
    step(1);
    check("bringup.s2", 32'(state), 32'd2);
    step(2);
    cdr_lock = 1'b1;
    step(5);
    check_outs("bringup.e9", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    check_outs("bringup.e10", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1);
    check_outs("bringup.e11", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step(7);
    check_outs("bringup.e18", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1);
    check_outs("bringup.e19", 3'd5, 1'b1, 1'b1, 1'b1, 1'b1);

    // CDR-only loss in READY, then requalify with 10-cycle latency.
    cdr_lock = 1'b0;
    step(2);
    check("cdrloss.e1", 32'(state), 32'd5);
    step(1);
    check_outs("cdrloss.e2", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    check("cdrloss.lost", 32'(lock_lost_cnt), 32'd0);
    cdr_lock = 1'b1;
    step(3);
    check("cdrrelock.e2", 32'(state), 32'd4);
    step(7);
    check_outs("cdrrelock.e9", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1);
    check_outs("cdrrelock.e10", 3'd5, 1'b1, 1'b1, 1'b1, 1'b1);

    // Simultaneous PLL and CDR drop: PLL wins, one loss counted.
    pll_lock = 1'b0;
    cdr_lock = 1'b0;
    step(2);
    check("bothloss.e1", 32'(state), 32'd5);
    step(1);
    check_outs("bothloss.e2", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bothloss.lost", 32'(lock_lost_cnt), 32'd1);

    // Saturation: 300 more qualified PLL losses.
    to_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1;
      wait_state(3'd3, 30, ok);
      if (!ok) to_cnt++;
      pll_lock = 1'b0;
      wait_state(3'd1, 10, ok);
      if (!ok) to_cnt++;
      if (i == 252) check("sat.254", 32'(lock_lost_cnt), 32'd254);
      if (i == 253) check("sat.255", 32'(lock_lost_cnt), 32'd255);
    end
    check("sat.held", 32'(lock_lost_cnt), 32'd255);
    check("sat.wait_budget", 32'(to_cnt), 32'd0);

    // Asynchronous reset mid-READY.
    pll_lock = 1'b1;
    cdr_lock = 1'b1;
    wait_state(3'd5, 40, ok);
    check("areset.reached_ready", 32'(ok), 32'd1);
    check("areset.rx_ready_before", 32'(rx_ready), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_outs("areset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("areset.timeout", 32'(timeout), 32'd0);
    check("areset.lost", 32'(lock_lost_cnt), 32'd0);
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
